// File: rtl/up_sample_pkg.sv
// Shared types and helpers for the 2x up-sampler.
// Contents: source-side state enum, default pixel width, counter-width function.
package up_sample_pkg;

  localparam int unsigned DATA_W = 8;

  // Where the next pixel is fetched from: the Gaussian FIFO or the line buffer.
  typedef enum logic {
    S_LIVE   = 1'b0,
    S_REPLAY = 1'b1
  } src_state_e;

  // Bits needed to count 0..n-1 (at least 1).
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((n - 32'd1) >= (32'd1 << i)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/up_sample_line_buf.sv
// One-row line buffer: simple dual-port RAM, DEPTH x DATA_W.
// Ports:
//   clk              - clock
//   we_i/waddr_i/wdata_i - write port
//   re_i/raddr_i     - read request; rdata_o valid the next cycle
//   rdata_o          - registered read data
module up_sample_line_buf
  import up_sample_pkg::*;
#(
  parameter int unsigned DEPTH  = 200,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned AW     = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Storage has no reset; contents after reset are don't-care.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/up_sample_x2.sv
// 2x spatial up-sampler: each FIFO pixel is emitted twice horizontally and
// every input row is replayed once from a line buffer (two output rows).
// Optional macro UP_SAMPLE_INTERP_EN: first beat of each pixel at column > 0
// becomes the rounded average of the previous and current pixel.
// Ports:
//   clk, rst (async, active-low)
//   empty, rd_en, din, valid - Gaussian FIFO read side (data one cycle after rd_en)
//   dout, valid_out, ready   - output valid/ready stream
//   frame_done               - pulse on acceptance of the last beat of a frame
module up_sample_x2
  import up_sample_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 200,
  parameter int unsigned IN_HEIGHT = 150,
  parameter int unsigned DATA_W    = up_sample_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              empty,
  output logic              rd_en,
  input  logic [DATA_W-1:0] din,
  input  logic              valid,
  output logic [DATA_W-1:0] dout,
  output logic              valid_out,
  input  logic              ready,
  output logic              frame_done
);

  localparam int unsigned CW = clog2(IN_WIDTH);
  localparam int unsigned RW = clog2(2 * IN_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IN_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(2 * IN_HEIGHT - 1);

  src_state_e        state_q, state_d;
  logic [CW-1:0]     rd_col_q, rd_col_d;
  logic              run_q;
  logic              pend_q, pend_d;
  src_state_e        pend_src_q, pend_src_d;
  logic [CW-1:0]     pend_col_q, pend_col_d;

  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] next_q, next_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              dup_q, dup_d;
  logic [CW-1:0]     out_col_q, out_col_d;
  logic [RW-1:0]     out_row_q, out_row_d;
  logic              valid_out_q, valid_out_d;
  logic [DATA_W-1:0] dout_q, dout_d;
`ifdef UP_SAMPLE_INTERP_EN
  logic [DATA_W-1:0] prev_q, prev_d;
  logic [DATA_W:0]   sum_c;
`endif

  logic              issue_c;
  logic              accept_c;
  logic              push_c;
  logic [DATA_W-1:0] px_c;
  logic [DATA_W-1:0] ram_rdata;

  // Source FSM: issue at most one read in flight, only into a free queue slot.
  // run_q keeps reads off during reset and the first cycle after release.
  always_comb begin
    state_d    = state_q;
    rd_col_d   = rd_col_q;
    pend_d     = 1'b0;
    pend_src_d = pend_src_q;
    pend_col_d = pend_col_q;
    issue_c    = 1'b0;
    if (run_q && !pend_q && (cnt_q != 2'd2)) begin
      case (state_q)
        S_LIVE:   issue_c = !empty;
        S_REPLAY: issue_c = 1'b1;
        default:  issue_c = 1'b0;
      endcase
    end
    if (issue_c) begin
      pend_d     = 1'b1;
      pend_src_d = state_q;
      pend_col_d = rd_col_q;
      if (rd_col_q == COL_LAST) begin
        rd_col_d = '0;
        state_d  = (state_q == S_LIVE) ? S_REPLAY : S_LIVE;
      end else begin
        rd_col_d = rd_col_q + CW'(1);
      end
    end
  end

  assign rd_en = issue_c && (state_q == S_LIVE);

  // Returning pixel: FIFO data for live reads, RAM data for replay reads.
  assign push_c   = pend_q && ((pend_src_q == S_REPLAY) || valid);
  assign px_c     = (pend_src_q == S_REPLAY) ? ram_rdata : din;
  assign accept_c = valid_out_q && ready;

  // Output side: queue update, beat phase, column/row counters, registered dout.
  always_comb begin
    hold_d    = hold_q;
    next_d    = next_q;
    cnt_d     = cnt_q;
    dup_d     = dup_q;
    out_col_d = out_col_q;
    out_row_d = out_row_q;
`ifdef UP_SAMPLE_INTERP_EN
    prev_d    = prev_q;
    sum_c     = '0;
`endif
    if (accept_c) begin
      if (!dup_q) begin
        dup_d = 1'b1;
      end else begin
        dup_d  = 1'b0;
        hold_d = next_q;
        cnt_d  = cnt_q - 2'd1;
`ifdef UP_SAMPLE_INTERP_EN
        prev_d = (out_col_q == COL_LAST) ? '0 : hold_q;
`endif
        if (out_col_q == COL_LAST) begin
          out_col_d = '0;
          out_row_d = (out_row_q == ROW_LAST) ? '0 : out_row_q + RW'(1);
        end else begin
          out_col_d = out_col_q + CW'(1);
        end
      end
    end
    // At most one entry is ever in flight, so a push never overflows.
    if (push_c) begin
      if (cnt_d == 2'd0) hold_d = px_c;
      else               next_d = px_c;
      cnt_d = cnt_d + 2'd1;
    end
    valid_out_d = (cnt_d != 2'd0);
    dout_d      = hold_d;
`ifdef UP_SAMPLE_INTERP_EN
    if (!dup_d && (out_col_d != '0)) begin
      sum_c  = {1'b0, prev_d} + {1'b0, hold_d} + (DATA_W + 1)'(1);
      dout_d = sum_c[DATA_W:1];
    end
`endif
  end

  assign frame_done = accept_c && dup_q && (out_col_q == COL_LAST) &&
                      (out_row_q == ROW_LAST);
  assign valid_out  = valid_out_q;
  assign dout       = dout_q;

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_LIVE;
      rd_col_q    <= '0;
      run_q       <= 1'b0;
      pend_q      <= 1'b0;
      pend_src_q  <= S_LIVE;
      pend_col_q  <= '0;
      hold_q      <= '0;
      next_q      <= '0;
      cnt_q       <= '0;
      dup_q       <= 1'b0;
      out_col_q   <= '0;
      out_row_q   <= '0;
      valid_out_q <= 1'b0;
      dout_q      <= '0;
`ifdef UP_SAMPLE_INTERP_EN
      prev_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rd_col_q    <= rd_col_d;
      run_q       <= 1'b1;
      pend_q      <= pend_d;
      pend_src_q  <= pend_src_d;
      pend_col_q  <= pend_col_d;
      hold_q      <= hold_d;
      next_q      <= next_d;
      cnt_q       <= cnt_d;
      dup_q       <= dup_d;
      out_col_q   <= out_col_d;
      out_row_q   <= out_row_d;
      valid_out_q <= valid_out_d;
      dout_q      <= dout_d;
`ifdef UP_SAMPLE_INTERP_EN
      prev_q      <= prev_d;
`endif
    end
  end

  // Live pixels are captured at their column for the replay pass.
  up_sample_line_buf #(
    .DEPTH  (IN_WIDTH),
    .DATA_W (DATA_W),
    .AW     (CW)
  ) u_line_buf (
    .clk     (clk),
    .we_i    (pend_q && (pend_src_q == S_LIVE) && valid),
    .waddr_i (pend_col_q),
    .wdata_i (din),
    .re_i    (issue_c && (state_q == S_REPLAY)),
    .raddr_i (rd_col_q),
    .rdata_o (ram_rdata)
  );

endmodule
